// File: rtl/md_pkg.sv
// ============================================================================
// Module : md_pkg
// Brief  : Shared types, size codes and helpers for the data-memory controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package md_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    localparam logic [1:0] TAM_BYTE = 2'b00;
    localparam logic [1:0] TAM_HALF = 2'b01;
    localparam logic [1:0] TAM_WORD = 2'b10;

    function automatic int larg_cont(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // The illegal size code is treated as a misalignment so it never reaches memory.
    function automatic logic desalinhado(input logic [1:0] tam, input logic [1:0] k);
        logic r;
        case (tam)
            TAM_BYTE: r = 1'b0;
            TAM_HALF: r = k[0];
            TAM_WORD: r = |k;
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_md_formatador.sv
// ============================================================================
// Module : formatador_md
// Brief  : Store lane/byte-enable generation and load lane select + extension.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module formatador_md
    import md_pkg::*;
(
    input  logic [1:0]      i_tam_esc,
    input  logic [1:0]      i_k_esc,
    input  logic [31:0]     i_dado_esc,
    output logic [3:0]      o_be,
    output logic [3:0][7:0] o_dado_rep,
    input  logic [1:0]      i_tam_ler,
    input  logic [1:0]      i_k_ler,
    input  logic            i_sinal,
    input  logic [31:0]     i_dado_mem,
    output logic [31:0]     o_dado_fmt
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be       = 4'b1111;
        o_dado_rep = i_dado_esc;
        case (i_tam_esc)
            TAM_BYTE: begin
                o_be       = 4'b0001 << i_k_esc;
                o_dado_rep = {4{i_dado_esc[7:0]}};
            end
            TAM_HALF: begin
                o_be       = i_k_esc[1] ? 4'b1100 : 4'b0011;
                o_dado_rep = {2{i_dado_esc[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_k_ler)
            2'd0:    w_byte = i_dado_mem[7:0];
            2'd1:    w_byte = i_dado_mem[15:8];
            2'd2:    w_byte = i_dado_mem[23:16];
            default: w_byte = i_dado_mem[31:24];
        endcase
        w_half = i_k_ler[1] ? i_dado_mem[31:16] : i_dado_mem[15:0];

        o_dado_fmt = i_dado_mem;
        case (i_tam_ler)
            TAM_BYTE: o_dado_fmt = {{24{i_sinal & w_byte[7]}}, w_byte};
            TAM_HALF: o_dado_fmt = {{16{i_sinal & w_half[15]}}, w_half};
            default:  ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/controlador_md.sv
// ============================================================================
// Module : controlador_md
// Brief  : Load/store req/ack controller with stall, formatting and writeback flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module controlador_md
    import md_pkg::*;
#(
    parameter int LARGURA_END = 32,
    parameter int TIMEOUT     = 16
)(
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_ler,
    input  logic                   i_escrever,
    input  logic [LARGURA_END-1:0] i_endereco,
    input  logic [31:0]            i_dado_escrita,
    input  logic [1:0]             i_tamanho,
    input  logic                   i_com_sinal,
    output logic                   o_ocupado,
    output logic [31:0]            o_dado_lido,
    output logic                   o_dado_valido,
    output logic                   o_flag_md,
    output logic                   o_erro_alinhamento,
    output logic                   o_erro_timeout,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [LARGURA_END-1:0] o_mem_end,
    output logic [3:0][7:0]        o_mem_dado_out,
    output logic [3:0]             o_mem_be,
    input  logic [31:0]            i_mem_dado_in,
    input  logic                   i_mem_ack
);

    localparam int                   LARG_CONT = larg_cont(TIMEOUT);
    localparam logic [LARG_CONT-1:0] c_limite  = LARG_CONT'(TIMEOUT - 1);

    estado_t                r_estado, w_prox;
    logic                   w_aceita, w_desal, w_fim_ack, w_fim_to;
    logic [LARG_CONT-1:0]   r_cont;
    logic                   r_we, r_sinal, r_mem_req;
    logic [1:0]             r_tam, r_k;
    logic [LARGURA_END-1:0] r_mem_end;
    logic [3:0]             r_mem_be, w_be;
    logic [3:0][7:0]        r_mem_dado, w_rep;
    logic [31:0]            r_dado_lido, w_fmt;
    logic                   r_dado_valido, r_flag, r_erro_al, r_erro_to;

    formatador_md u_formatador (
        .i_tam_esc  (i_tamanho),
        .i_k_esc    (i_endereco[1:0]),
        .i_dado_esc (i_dado_escrita),
        .o_be       (w_be),
        .o_dado_rep (w_rep),
        .i_tam_ler  (r_tam),
        .i_k_ler    (r_k),
        .i_sinal    (r_sinal),
        .i_dado_mem (i_mem_dado_in),
        .o_dado_fmt (w_fmt)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_estado <= OCIOSO;
        else         r_estado <= w_prox;
    end

    always_comb begin
        w_prox    = r_estado;
        w_aceita  = 1'b0;
        w_desal   = 1'b0;
        w_fim_ack = 1'b0;
        w_fim_to  = 1'b0;
        o_ocupado = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (i_ler | i_escrever) begin
                    w_aceita  = 1'b1;
                    o_ocupado = 1'b1;
                    w_desal   = desalinhado(i_tamanho, i_endereco[1:0]);
                    w_prox    = w_desal ? RESPOSTA : ACESSO;
                end
            end
            ACESSO: begin
                o_ocupado = 1'b1;
                if (i_mem_ack) begin
                    w_fim_ack = 1'b1;
                    w_prox    = RESPOSTA;
                end else if (r_cont == c_limite) begin
                    w_fim_to = 1'b1;
                    w_prox   = RESPOSTA;
                end
            end
            RESPOSTA: w_prox = OCIOSO;
            default:  w_prox = OCIOSO;
        endcase
        if (i_reset) o_ocupado = 1'b0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cont        <= '0;
            r_we          <= 1'b0;
            r_sinal       <= 1'b0;
            r_tam         <= 2'b00;
            r_k           <= 2'b00;
            r_mem_req     <= 1'b0;
            r_mem_end     <= '0;
            r_mem_be      <= 4'b0000;
            r_mem_dado    <= '0;
            r_dado_lido   <= 32'd0;
            r_dado_valido <= 1'b0;
            r_flag        <= 1'b0;
            r_erro_al     <= 1'b0;
            r_erro_to     <= 1'b0;
        end else begin
            r_dado_valido <= 1'b0;
            r_erro_al     <= 1'b0;
            r_erro_to     <= 1'b0;
            if (w_aceita) begin
                // Store takes priority when both request levels are high.
                r_flag     <= 1'b0;
                r_we       <= i_escrever;
                r_tam      <= i_tamanho;
                r_k        <= i_endereco[1:0];
                r_sinal    <= i_com_sinal;
                r_mem_end  <= {i_endereco[LARGURA_END-1:2], 2'b00};
                r_mem_be   <= w_be;
                r_mem_dado <= w_rep;
                r_cont     <= '0;
                r_mem_req  <= ~w_desal;
                r_erro_al  <= w_desal;
            end
            if (r_estado == ACESSO) begin
                if (w_fim_ack) begin
                    r_mem_req <= 1'b0;
                    if (!r_we) begin
                        r_dado_lido   <= w_fmt;
                        r_dado_valido <= 1'b1;
                        r_flag        <= 1'b1;
                    end
                end else if (w_fim_to) begin
                    r_mem_req <= 1'b0;
                    r_erro_to <= 1'b1;
                end else begin
                    r_cont <= r_cont + LARG_CONT'(1);
                end
            end
        end
    end

    assign o_dado_lido        = r_dado_lido;
    assign o_dado_valido      = r_dado_valido;
    assign o_flag_md          = r_flag;
    assign o_erro_alinhamento = r_erro_al;
    assign o_erro_timeout     = r_erro_to;
    assign o_mem_req          = r_mem_req;
    assign o_mem_we           = r_we;
    assign o_mem_end          = r_mem_end;
    assign o_mem_dado_out     = r_mem_dado;
    assign o_mem_be           = r_mem_be;

endmodule

`default_nettype wire

// File: tb/tb_controlador_md.sv
// ============================================================================
// Module : tb_controlador_md
// Brief  : Directed self-checking bench for controlador_md.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_controlador_md;

    logic            clk = 1'b0;
    logic            i_reset, i_ler, i_escrever, i_com_sinal, i_mem_ack;
    logic [31:0]     i_endereco, i_dado_escrita, i_mem_dado_in;
    logic [1:0]      i_tamanho;
    logic            o_ocupado, o_dado_valido, o_flag_md, o_erro_alinhamento, o_erro_timeout;
    logic            o_mem_req, o_mem_we;
    logic [31:0]     o_dado_lido, o_mem_end;
    logic [3:0][7:0] o_mem_dado_out;
    logic [3:0]      o_mem_be;

    int total = 0;
    int bad   = 0;
    int n_req, lat;

    always #5 clk = ~clk;

    controlador_md #(.LARGURA_END(32), .TIMEOUT(16)) dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_ler              (i_ler),
        .i_escrever         (i_escrever),
        .i_endereco         (i_endereco),
        .i_dado_escrita     (i_dado_escrita),
        .i_tamanho          (i_tamanho),
        .i_com_sinal        (i_com_sinal),
        .o_ocupado          (o_ocupado),
        .o_dado_lido        (o_dado_lido),
        .o_dado_valido      (o_dado_valido),
        .o_flag_md          (o_flag_md),
        .o_erro_alinhamento (o_erro_alinhamento),
        .o_erro_timeout     (o_erro_timeout),
        .o_mem_req          (o_mem_req),
        .o_mem_we           (o_mem_we),
        .o_mem_end          (o_mem_end),
        .o_mem_dado_out     (o_mem_dado_out),
        .o_mem_be           (o_mem_be),
        .i_mem_dado_in      (i_mem_dado_in),
        .i_mem_ack          (i_mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic pedido(input logic ler, input logic esc, input logic [1:0] tam,
                          input logic [31:0] addr, input logic [31:0] dado, input logic sinal);
        @(negedge clk);
        i_ler          = ler;
        i_escrever     = esc;
        i_tamanho      = tam;
        i_endereco     = addr;
        i_dado_escrita = dado;
        i_com_sinal    = sinal;
        #1;
        chk("ocupado_pedido", 32'(o_ocupado), 1);
    endtask

    // Returns at the first negedge where ocupado is low (the response cycle).
    task automatic resposta(input int ack_em, input logic [31:0] rdata,
                            output int nr, output int lt);
        logic fim;
        fim = 1'b0;
        nr  = 0;
        lt  = 0;
        for (int i = 0; i < 40 && !fim; i++) begin
            @(negedge clk);
            i_mem_ack = 1'b0;
            lt++;
            if (!o_ocupado) fim = 1'b1;
            else if (o_mem_req) begin
                nr++;
                if (nr == ack_em) begin
                    i_mem_ack     = 1'b1;
                    i_mem_dado_in = rdata;
                end
            end
        end
        if (!fim) chk("limite_resposta", 0, 1);
    endtask

    task automatic solta();
        i_ler      = 1'b0;
        i_escrever = 1'b0;
        i_mem_ack  = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_ler = 1'b1; i_escrever = 1'b0; i_com_sinal = 1'b0;
        i_mem_ack = 1'b0; i_endereco = 32'd0; i_dado_escrita = 32'd0;
        i_mem_dado_in = 32'd0; i_tamanho = 2'b10;
        repeat (2) @(negedge clk);
        chk("rst_ocupado", 32'(o_ocupado), 0);
        chk("rst_req", 32'(o_mem_req), 0);
        chk("rst_flag", 32'(o_flag_md), 0);
        chk("rst_lido", o_dado_lido, 32'h0);
        chk("rst_be", 32'(o_mem_be), 0);
        i_reset = 1'b0;
        i_ler   = 1'b0;

        // Word store, ack in third request cycle
        pedido(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        resposta(3, 32'h0, n_req, lat);
        chk("st_w_nreq", 32'(n_req), 3);
        chk("st_w_we", 32'(o_mem_we), 1);
        chk("st_w_end", o_mem_end, 32'h10);
        chk("st_w_be", 32'(o_mem_be), 32'hF);
        chk("st_w_dado", o_mem_dado_out, 32'hDEADBEEF);
        chk("st_w_valido", 32'(o_dado_valido), 0);
        chk("st_w_req_off", 32'(o_mem_req), 0);
        solta();

        // Signed byte load, same-cycle ack
        pedido(1'b1, 1'b0, 2'b00, 32'h13, 32'h0, 1'b1);
        resposta(1, 32'h80123456, n_req, lat);
        chk("ld_b_lat", 32'(lat), 2);
        chk("ld_b_be", 32'(o_mem_be), 32'h8);
        chk("ld_b_we", 32'(o_mem_we), 0);
        chk("ld_bs_dado", o_dado_lido, 32'hFFFFFF80);
        chk("ld_bs_valido", 32'(o_dado_valido), 1);
        chk("ld_bs_flag", 32'(o_flag_md), 1);
        solta();
        @(negedge clk);
        chk("ld_bs_pulso", 32'(o_dado_valido), 0);
        chk("ld_bs_flag_hold", 32'(o_flag_md), 1);

        // Unsigned byte load, same address
        pedido(1'b1, 1'b0, 2'b00, 32'h13, 32'h0, 1'b0);
        resposta(1, 32'h80123456, n_req, lat);
        chk("ld_bu_dado", o_dado_lido, 32'h00000080);
        chk("ld_bu_flag", 32'(o_flag_md), 1);
        solta();

        // Misaligned word load clears the flag, no memory request
        pedido(1'b1, 1'b0, 2'b10, 32'h06, 32'h0, 1'b0);
        resposta(1, 32'h0, n_req, lat);
        chk("mis_lat", 32'(lat), 1);
        chk("mis_nreq", 32'(n_req), 0);
        chk("mis_erro", 32'(o_erro_alinhamento), 1);
        chk("mis_valido", 32'(o_dado_valido), 0);
        chk("mis_flag", 32'(o_flag_md), 0);
        solta();
        @(negedge clk);
        chk("mis_pulso", 32'(o_erro_alinhamento), 0);

        // Signed half load from upper half
        pedido(1'b1, 1'b0, 2'b01, 32'h02, 32'h0, 1'b1);
        resposta(2, 32'h80011234, n_req, lat);
        chk("ld_h_be", 32'(o_mem_be), 32'hC);
        chk("ld_h_dado", o_dado_lido, 32'hFFFF8001);
        solta();

        // Signed byte load with clear sign bit
        pedido(1'b1, 1'b0, 2'b00, 32'h11, 32'h0, 1'b1);
        resposta(1, 32'h00007F00, n_req, lat);
        chk("ld_b1_be", 32'(o_mem_be), 32'h2);
        chk("ld_b1_dado", o_dado_lido, 32'h0000007F);
        solta();

        // Half store at a=0x22
        pedido(1'b0, 1'b1, 2'b01, 32'h22, 32'h0000ABCD, 1'b0);
        resposta(2, 32'h0, n_req, lat);
        chk("st_h_end", o_mem_end, 32'h20);
        chk("st_h_be", 32'(o_mem_be), 32'hC);
        chk("st_h_dado", o_mem_dado_out, 32'hABCDABCD);
        chk("st_h_flag", 32'(o_flag_md), 0);
        solta();

        // Load and store together: store wins
        pedido(1'b1, 1'b1, 2'b10, 32'h30, 32'h01020304, 1'b0);
        resposta(1, 32'h55555555, n_req, lat);
        chk("ambos_we", 32'(o_mem_we), 1);
        chk("ambos_valido", 32'(o_dado_valido), 0);
        solta();

        // Illegal size code
        pedido(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 1'b0);
        resposta(1, 32'h0, n_req, lat);
        chk("tam11_erro", 32'(o_erro_alinhamento), 1);
        chk("tam11_nreq", 32'(n_req), 0);
        solta();

        // Timeout: no ack ever
        pedido(1'b1, 1'b0, 2'b10, 32'h44, 32'h0, 1'b0);
        resposta(0, 32'h0, n_req, lat);
        chk("to_nreq", 32'(n_req), 16);
        chk("to_erro", 32'(o_erro_timeout), 1);
        chk("to_valido", 32'(o_dado_valido), 0);
        chk("to_req_off", 32'(o_mem_req), 0);
        solta();
        @(negedge clk);
        chk("to_pulso", 32'(o_erro_timeout), 0);
        chk("to_ocioso", 32'(o_ocupado), 0);

        // Reset mid-access, late ack ignored
        pedido(1'b1, 1'b0, 2'b10, 32'h50, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_mid_req_pre", 32'(o_mem_req), 1);
        i_reset = 1'b1;
        i_ler   = 1'b0;
        #1;
        chk("rst_mid_req", 32'(o_mem_req), 0);
        chk("rst_mid_ocupado", 32'(o_ocupado), 0);
        i_mem_ack     = 1'b1;
        i_mem_dado_in = 32'hCAFEF00D;
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk("late_ack_valido", 32'(o_dado_valido), 0);
        chk("late_ack_req", 32'(o_mem_req), 0);
        chk("late_ack_lido", o_dado_lido, 32'h0);

        pedido(1'b1, 1'b0, 2'b10, 32'h50, 32'h0, 1'b0);
        resposta(1, 32'h12345678, n_req, lat);
        chk("pos_rst_lat", 32'(lat), 2);
        chk("pos_rst_valido", 32'(o_dado_valido), 1);
        chk("pos_rst_dado", o_dado_lido, 32'h12345678);
        solta();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
